fetch_unit: RTL and testbench

//  Instruction-fetch stage placed ahead of the FI/ID pipeline register. Holds the fetch PC and runs a
//  req/ack handshake to a variable-latency instruction memory, with at most one request outstanding.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage ahead of the FI/ID register.
// Runs a single-outstanding req/ack handshake to instruction memory, buffers
// returned words in a small {pc,inst} queue, holds the head under decode
// stall, and on redirect flushes the queue and discards any in-flight word.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int          AW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0] QFULL = (AW + 1)'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   drop_addr;
    logic [31:0]   q_pc   [QDEPTH];
    logic [31:0]   q_inst [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_after_pop;
    logic [AW:0]   count_next;
    logic          ack;
    logic          push;
    logic          pop;
    logic          space_idle;
    logic          space_req;
    logic [31:0]   target_pc;

    // Instruction addresses are word aligned; low bits of a target are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

    // Handshake qualification, queue occupancy arithmetic and space decisions.
    // Space is judged after this cycle's pop; the outstanding request is not
    // counted, so a push can never land on a full queue.
    always_comb begin
        ack             = imem_req && imem_ack;
        pop             = inst_valid && !stall && !redirect;
        push            = (state == REQ) && ack && !redirect;
        count_after_pop = count - {{AW{1'b0}}, pop};
        count_next      = count_after_pop + {{AW{1'b0}}, push};
        space_idle      = (count_after_pop < QFULL);
        space_req       = (count_next < QFULL);
        target_pc       = word_align(redirect_pc);
    end

    // Queue head drives the decode side directly from storage registers;
    // nop and zero PC are presented whenever the queue is empty.
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? q_inst[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : 32'h0;

    // While dropping, the abandoned request keeps its original address.
    assign imem_addr  = (state == DROP) ? drop_addr : fetch_pc;

    // Fetch FSM: owns the request line and the fetch PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        fetch_pc <= target_pc;
                    end else if (space_idle) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        // Completed word is discarded; an uncompleted one must
                        // still be waited out before the target is requested.
                        fetch_pc <= target_pc;
                        if (!ack) begin
                            state <= DROP;
                        end
                    end else if (ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (!space_req) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (redirect) begin
                        fetch_pc <= target_pc;
                    end
                    if (ack) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Remember the address of a request abandoned by a redirect.
    always_ff @(posedge clk) begin
        if ((state == REQ) && redirect && !ack) begin
            drop_addr <= fetch_pc;
        end
    end

    // Queue pointers and occupancy; redirect empties the queue outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Queue storage: capture the returned word with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= fetch_pc;
            q_inst[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized stall/redirect/latency
// traffic, checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model state
    int lat      = 1;
    int wcnt     = 0;
    bit rand_lat = 1'b0;

    // reference model state
    logic [31:0] exp_pc    = RESET_PC;
    bit          flush_chk = 1'b0;
    bit          hold_chk  = 1'b0;
    logic [31:0] hold_pc   = 32'h0;
    bit          pend      = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          starve    = 0;
    bit          fired     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Content the memory returns for any address (never zero near the test PCs).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A11;
    endfunction

    // One clock cycle, executed at the falling edge: check what the last
    // rising edge produced, play memory, apply decode inputs, advance model.
    // mode: 0 none, 1 redirect, 2 redirect only if a request is waiting,
    // 3 redirect only in an ack cycle.
    task automatic tick(input logic st, input int mode, input logic [31:0] rpc);
        @(negedge clk);
        if (pend) begin
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_held", imem_addr, pend_addr);
        end
        if (flush_chk) check("flush_valid", 32'(inst_valid), 32'd0);
        if (hold_chk) begin
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_pc", inst_pc, hold_pc);
        end
        if (inst_valid) begin
            check("inst_data", inst, mem_word(inst_pc));
        end else begin
            check("nop_inst", inst, 32'h0);
            check("nop_pc", inst_pc, 32'h0);
        end

        if (imem_ack) begin
            imem_ack = 1'b0;
            wcnt     = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end
        imem_rdata = $urandom;
        if (imem_req) begin
            if (wcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        pend      = imem_req && !imem_ack;
        pend_addr = imem_addr;

        fired = (mode == 1) || (mode == 2 && imem_req && !imem_ack) || (mode == 3 && imem_ack);
        stall       = st;
        redirect    = fired;
        redirect_pc = rpc;

        if (fired) begin
            exp_pc = rpc & 32'hFFFF_FFFC;
            starve = 0;
        end else if (inst_valid && !st) begin
            check("order_pc", inst_pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
            starve = 0;
        end else if (st) begin
            starve = 0;
        end else begin
            starve++;
        end
        if (starve >= 40) begin
            check("starve_cycles", 32'(starve), 32'd0);
            starve = 0;
        end
        flush_chk = fired;
        hold_chk  = !fired && st && inst_valid;
        hold_pc   = inst_pc;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        imem_ack  = 1'b0;
        wcnt      = 0;
        pend      = 1'b0;
        flush_chk = 1'b0;
        hold_chk  = 1'b0;
        exp_pc    = RESET_PC;
        starve    = 0;
        redirect  = 1'b0;
        stall     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [31:0] old_addr;

        // 1: reset release, one wait cycle per access
        rand_lat = 1'b0;
        lat      = 1;
        do_reset();
        tick(1'b0, 0, 32'h0);
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", imem_addr, RESET_PC);
        check("t1_valid_c1", 32'(inst_valid), 32'd0);
        tick(1'b0, 0, 32'h0);
        check("t1_valid_c2", 32'(inst_valid), 32'd0);
        tick(1'b0, 0, 32'h0);
        check("t1_valid_c3", 32'(inst_valid), 32'd1);
        check("t1_pc_c3", inst_pc, RESET_PC);
        for (int i = 0; i < 10; i++) tick(1'b0, 0, 32'h0);

        // 2: stall with zero-wait memory fills the queue and stops fetching
        lat = 0;
        for (int i = 0; i < 8; i++) tick(1'b1, 0, 32'h0);
        check("t2_req_off", 32'(imem_req), 32'd0);
        check("t2_valid", 32'(inst_valid), 32'd1);
        for (int i = 0; i < 8; i++) tick(1'b0, 0, 32'h0);

        // 3: redirect while a slow request is waiting
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b0, 2, 32'h0000_0100);
            found = fired;
        end
        check("t3_fired", 32'(found), 32'd1);
        old_addr = pend_addr;
        found    = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b0, 0, 32'h0);
            if (imem_req && imem_addr != old_addr) begin
                check("t3_next_addr", imem_addr, 32'h0000_0100);
                found = 1'b1;
            end
        end
        check("t3_resumed", 32'(found), 32'd1);
        for (int i = 0; i < 12; i++) tick(1'b0, 0, 32'h0);

        // 4: redirect coinciding with an ack
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b0, 3, 32'h0000_0200);
            found = fired;
        end
        check("t4_fired", 32'(found), 32'd1);
        tick(1'b0, 0, 32'h0);
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_addr", imem_addr, 32'h0000_0200);
        for (int i = 0; i < 8; i++) tick(1'b0, 0, 32'h0);

        // 5: redirect while full and stalled
        for (int i = 0; i < 8; i++) tick(1'b1, 0, 32'h0);
        check("t5_full_req", 32'(imem_req), 32'd0);
        tick(1'b1, 1, 32'h0000_0303);
        tick(1'b1, 0, 32'h0);
        check("t5_req", 32'(imem_req), 32'd1);
        check("t5_addr", imem_addr, 32'h0000_0300);
        for (int i = 0; i < 4; i++) tick(1'b1, 0, 32'h0);
        check("t5_valid", 32'(inst_valid), 32'd1);
        check("t5_pc", inst_pc, 32'h0000_0300);
        for (int i = 0; i < 8; i++) tick(1'b0, 0, 32'h0);

        // 6: reset in the middle of a transaction
        lat   = 5;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b0, 0, 32'h0);
            found = imem_req && !imem_ack;
        end
        check("t6_pending", 32'(found), 32'd1);
        lat = 1;
        do_reset();
        tick(1'b0, 0, 32'h0);
        check("t6_req", 32'(imem_req), 32'd1);
        check("t6_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 6; i++) tick(1'b0, 0, 32'h0);

        // randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int          r;
            logic        st;
            logic [31:0] rpc;
            r   = $urandom_range(0, 99);
            st  = ($urandom_range(0, 9) < 3);
            rpc = (r == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
            tick(st, (r < 5) ? 1 : 0, rpc);
        end
        for (int i = 0; i < 20; i++) tick(1'b0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
